// File: rtl/branch_resolve_stage.sv
// branch_resolve_stage
// Execute-side branch resolution. Holds one decoded instruction, works out
// the real direction and target of B-type, JAL and JALR, and emits exactly
// one training/redirect report per control-flow instruction. It also forms
// the link value and hands the instruction to the memory stage.
//
// Optional build macro: BRU_PERF_CNT_EN
//   defined   -> branch_cnt / mispred_cnt are live 32-bit wrapping counters
//   undefined -> both count ports are tied to 0 and no counter flops exist
module branch_resolve_stage #(
    parameter int N = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_to_e_valid,
    output logic          e_allow_in,
    output logic          e_to_m_valid,
    input  logic          m_allow_in,
    input  logic [31:0]   d_pc,
    input  logic [6:0]    d_opcode,
    input  logic [9:0]    d_funct,
    input  logic [31:0]   d_imm,
    input  logic [31:0]   d_rs1_val,
    input  logic [31:0]   d_rs2_val,
    input  logic          d_is_jump_instr,
    input  logic          d_pred_taken,
    input  logic [31:0]   d_pred_next_pc,
    input  logic [N-1:0]  d_pred_history,
    output logic          e_valid,
    output logic          e_is_jump_instr,
    output logic          fact_taken,
    output logic          fact_success,
    output logic [N-1:0]  train_history,
    output logic [31:0]   fact_pc,
    output logic          e_flush,
    output logic [31:0]   e_pc,
    output logic [31:0]   e_link,
    output logic [31:0]   branch_cnt,
    output logic [31:0]   mispred_cnt
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Stage registers
    logic          e_valid_reg;
    logic          reported_reg;
    logic [31:0]   pc_reg;
    logic [6:0]    opcode_reg;
    logic [2:0]    funct3_reg;
    logic [31:0]   imm_reg;
    logic [31:0]   rs1_reg;
    logic [31:0]   rs2_reg;
    logic          is_jump_reg;
    logic [31:0]   pred_next_pc_reg;
    logic [N-1:0]  history_reg;

    // Fields this stage does not consume (upper funct bits, predicted
    // direction: the next-PC comparison already covers direction).
    logic          unused_inputs;
    assign unused_inputs = &{1'b0, d_funct[9:3], d_pred_taken};

    // Combinational resolution results
    logic          is_branch;
    logic          is_jal;
    logic          is_jalr;
    logic          cond_taken;
    logic          taken;
    logic [31:0]   pc_plus4;
    logic [31:0]   target;
    logic [31:0]   next_pc;
    logic          success;
    logic          strobe;
    logic          flush;
    logic          load;

    assign is_branch = (opcode_reg == OP_BRANCH);
    assign is_jal    = (opcode_reg == OP_JAL);
    assign is_jalr   = (opcode_reg == OP_JALR);
    assign pc_plus4  = pc_reg + 32'd4;

    // Branch condition from the registered func3; reserved encodings fall through as not taken
    always_comb begin
        cond_taken = 1'b0;
        case (funct3_reg)
            F3_BEQ:  cond_taken = (rs1_reg == rs2_reg);
            F3_BNE:  cond_taken = (rs1_reg != rs2_reg);
            F3_BLT:  cond_taken = ($signed(rs1_reg) <  $signed(rs2_reg));
            F3_BGE:  cond_taken = ($signed(rs1_reg) >= $signed(rs2_reg));
            F3_BLTU: cond_taken = (rs1_reg <  rs2_reg);
            F3_BGEU: cond_taken = (rs1_reg >= rs2_reg);
            default: cond_taken = 1'b0;
        endcase
    end

    // Direction and target selection; jumps are unconditionally taken
    always_comb begin
        taken  = 1'b0;
        target = pc_reg + imm_reg;
        if (is_branch) begin
            taken = cond_taken;
        end else if (is_jal) begin
            taken = 1'b1;
        end else if (is_jalr) begin
            taken  = 1'b1;
            target = (rs1_reg + imm_reg) & ~32'd1;
        end
    end

    // The prediction is judged on the PC fetch actually steered to, so a
    // correct direction with a stale target still counts as a mispredict.
    assign next_pc = taken ? target : pc_plus4;
    assign success = (pred_next_pc_reg == next_pc);

    // One report per instruction: the reported flag masks later stall cycles
    assign strobe = e_valid_reg & is_jump_reg & ~reported_reg;
    assign flush  = strobe & ~success;

    // A flush squashes whatever decode offers in the same cycle
    assign e_allow_in = ~e_valid_reg | m_allow_in;
    assign load       = d_to_e_valid & e_allow_in & ~flush;

    // Occupancy and report-once tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid_reg  <= 1'b0;
            reported_reg <= 1'b0;
        end else begin
            if (load) begin
                e_valid_reg  <= 1'b1;
                reported_reg <= 1'b0;
            end else begin
                if (m_allow_in) begin
                    e_valid_reg <= 1'b0;
                end
                if (strobe) begin
                    reported_reg <= 1'b1;
                end
            end
        end
    end

    // Payload capture on every accepted instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg           <= '0;
            opcode_reg       <= '0;
            funct3_reg       <= '0;
            imm_reg          <= '0;
            rs1_reg          <= '0;
            rs2_reg          <= '0;
            is_jump_reg      <= 1'b0;
            pred_next_pc_reg <= '0;
            history_reg      <= '0;
        end else if (load) begin
            pc_reg           <= d_pc;
            opcode_reg       <= d_opcode;
            funct3_reg       <= d_funct[2:0];
            imm_reg          <= d_imm;
            rs1_reg          <= d_rs1_val;
            rs2_reg          <= d_rs2_val;
            is_jump_reg      <= d_is_jump_instr;
            pred_next_pc_reg <= d_pred_next_pc;
            history_reg      <= d_pred_history;
        end
    end

    // Result outputs are held at 0 while the stage is empty so the
    // post-reset state is all zeros; while a live instruction is held they
    // keep reflecting it even after its report has gone out.
    always_comb begin
        fact_taken   = 1'b0;
        fact_success = 1'b0;
        fact_pc      = '0;
        e_link       = '0;
        if (e_valid_reg) begin
            fact_taken   = taken;
            fact_success = success;
            fact_pc      = next_pc;
            if (is_jal || is_jalr) begin
                e_link = pc_plus4;
            end
        end
    end

    assign e_valid         = e_valid_reg;
    assign e_to_m_valid    = e_valid_reg;
    assign e_is_jump_instr = strobe;
    assign e_flush         = flush;
    assign e_pc            = pc_reg;
    assign train_history   = history_reg;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt_reg;
    logic [31:0] mispred_cnt_reg;

    // Performance counters; wrap naturally, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (strobe) begin
                branch_cnt_reg <= branch_cnt_reg + 32'd1;
            end
            if (flush) begin
                mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;
`else
    assign branch_cnt  = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_stage.sv
// tb_branch_resolve_stage
// Directed stimulus with a scoreboard: each issued control-flow instruction
// pushes its hand-computed report; a monitor pops and compares on every
// report strobe. Build with BRU_PERF_CNT_EN to exercise the counters.
module tb_branch_resolve_stage;

    localparam int N = 12;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic          clk;
    logic          rst;
    logic          d_to_e_valid;
    logic          e_allow_in;
    logic          e_to_m_valid;
    logic          m_allow_in;
    logic [31:0]   d_pc;
    logic [6:0]    d_opcode;
    logic [9:0]    d_funct;
    logic [31:0]   d_imm;
    logic [31:0]   d_rs1_val;
    logic [31:0]   d_rs2_val;
    logic          d_is_jump_instr;
    logic          d_pred_taken;
    logic [31:0]   d_pred_next_pc;
    logic [N-1:0]  d_pred_history;
    logic          e_valid;
    logic          e_is_jump_instr;
    logic          fact_taken;
    logic          fact_success;
    logic [N-1:0]  train_history;
    logic [31:0]   fact_pc;
    logic          e_flush;
    logic [31:0]   e_pc;
    logic [31:0]   e_link;
    logic [31:0]   branch_cnt;
    logic [31:0]   mispred_cnt;

    branch_resolve_stage #(.N(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .d_to_e_valid    (d_to_e_valid),
        .e_allow_in      (e_allow_in),
        .e_to_m_valid    (e_to_m_valid),
        .m_allow_in      (m_allow_in),
        .d_pc            (d_pc),
        .d_opcode        (d_opcode),
        .d_funct         (d_funct),
        .d_imm           (d_imm),
        .d_rs1_val       (d_rs1_val),
        .d_rs2_val       (d_rs2_val),
        .d_is_jump_instr (d_is_jump_instr),
        .d_pred_taken    (d_pred_taken),
        .d_pred_next_pc  (d_pred_next_pc),
        .d_pred_history  (d_pred_history),
        .e_valid         (e_valid),
        .e_is_jump_instr (e_is_jump_instr),
        .fact_taken      (fact_taken),
        .fact_success    (fact_success),
        .train_history   (train_history),
        .fact_pc         (fact_pc),
        .e_flush         (e_flush),
        .e_pc            (e_pc),
        .e_link          (e_link),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic         taken;
        logic         success;
        logic         flush;
        logic [31:0]  fpc;
        logic [31:0]  link;
        logic [N-1:0] hist;
        logic [31:0]  pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   next_id  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every report strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst && e_is_jump_instr) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL report_unexpected: got strobe pc=0x%08h expected none", e_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (fact_taken !== e.taken || fact_success !== e.success ||
                    e_flush !== e.flush || fact_pc !== e.fpc ||
                    e_link !== e.link || train_history !== e.hist || e_pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL report_%0d: got pc=%h taken=%b ok=%b flush=%b fpc=%h link=%h hist=%h expected pc=%h taken=%b ok=%b flush=%b fpc=%h link=%h hist=%h",
                             e.id, e_pc, fact_taken, fact_success, e_flush, fact_pc, e_link, train_history,
                             e.pc, e.taken, e.success, e.flush, e.fpc, e.link, e.hist);
                end else begin
                    $display("report %0d pc=0x%08h taken=%b ok=%b flush=%b fpc=0x%08h link=0x%08h",
                             e.id, e_pc, fact_taken, fact_success, e_flush, fact_pc, e_link);
                end
            end
        end
    end

    // Present one instruction and hold it until the stage takes it
    task automatic issue(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pred, input logic [N-1:0] hist, input logic jmp,
                         input logic exp_taken, input logic [31:0] exp_fpc, input logic [31:0] exp_link);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!(e_allow_in && !e_flush) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited >= 50) begin
            n_fail++;
            $display("FAIL issue_timeout: got e_allow_in=%b expected 1 within 50 cycles", e_allow_in);
        end
        d_pc            = pc;
        d_opcode        = op;
        d_funct         = {7'b0, f3};
        d_imm           = imm;
        d_rs1_val       = rs1;
        d_rs2_val       = rs2;
        d_is_jump_instr = jmp;
        d_pred_taken    = (pred != pc + 32'd4);
        d_pred_next_pc  = pred;
        d_pred_history  = hist;
        d_to_e_valid    = 1'b1;
        if (jmp) begin
            e.id      = next_id;
            e.taken   = exp_taken;
            e.fpc     = exp_fpc;
            e.success = (pred == exp_fpc);
            e.flush   = (pred != exp_fpc);
            e.link    = exp_link;
            e.hist    = hist;
            e.pc      = pc;
            sb.push_back(e);
            next_id++;
        end
        @(posedge clk);
        #1;
        d_to_e_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int waited;
        waited = 0;
        @(negedge clk);
        while (e_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        rst = 1'b0;
        d_to_e_valid = 1'b0;
        m_allow_in = 1'b1;
        d_pc = '0; d_opcode = '0; d_funct = '0; d_imm = '0;
        d_rs1_val = '0; d_rs2_val = '0; d_is_jump_instr = 1'b0;
        d_pred_taken = 1'b0; d_pred_next_pc = '0; d_pred_history = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_e_valid", {31'b0, e_valid}, 32'd0);
        check("rst_e_allow_in", {31'b0, e_allow_in}, 32'd1);
        check("rst_e_to_m_valid", {31'b0, e_to_m_valid}, 32'd0);
        check("rst_fact_pc", fact_pc, 32'd0);
        check("rst_e_flush", {31'b0, e_flush}, 32'd0);
        check("rst_e_pc", e_pc, 32'd0);
        rst = 1'b1;

        // BEQ taken, correctly predicted
        issue(32'h80000010, OP_B, 3'b000, 32'h20, 32'd5, 32'd5, 32'h80000030, 12'hABC, 1'b1,
              1'b1, 32'h80000030, 32'h0);
        // BLT signed: -1 < 1 taken, fetch went sequential -> mispredict
        issue(32'h80000040, OP_B, 3'b100, 32'h40, 32'hFFFFFFFF, 32'd1, 32'h80000044, 12'h123, 1'b1,
              1'b1, 32'h80000080, 32'h0);
        // BLTU: 0xFFFFFFFF < 1 unsigned false, sequential prediction right
        issue(32'h80000050, OP_B, 3'b110, 32'h40, 32'hFFFFFFFF, 32'd1, 32'h80000054, 12'h456, 1'b1,
              1'b0, 32'h80000054, 32'h0);
        // JALR clears bit 0 of rs1+imm
        issue(32'h80000100, OP_JALR, 3'b000, 32'd4, 32'h80001003, 32'd0, 32'h80001006, 12'h789, 1'b1,
              1'b1, 32'h80001006, 32'h80000104);
        // JAL backwards (negative immediate)
        issue(32'h80000200, OP_JAL, 3'b000, 32'hFFFFFF00, 32'd0, 32'd0, 32'h80000100, 12'hFFF, 1'b1,
              1'b1, 32'h80000100, 32'h80000204);
        // Reserved func3 on a B-type -> not taken
        issue(32'h80000700, OP_B, 3'b010, 32'h40, 32'd7, 32'd7, 32'h80000704, 12'h001, 1'b1,
              1'b0, 32'h80000704, 32'h0);
        // Back-to-back BGEU pair: second loads as the first departs
        issue(32'h80000500, OP_B, 3'b111, 32'h100, 32'd3, 32'd3, 32'h80000600, 12'h0F0, 1'b1,
              1'b1, 32'h80000600, 32'h0);
        issue(32'h80000600, OP_B, 3'b111, 32'h100, 32'd2, 32'd5, 32'h80000604, 12'h00F, 1'b1,
              1'b0, 32'h80000604, 32'h0);

        // Non-jump instruction passes through with no report and zero link
        issue(32'h80000800, OP_ALU, 3'b000, 32'h0, 32'd1, 32'd2, 32'h80000804, 12'h000, 1'b0,
              1'b0, 32'h0, 32'h0);
        @(negedge clk);
        wait_empty();

        // BNE mispredict held by a 5-cycle memory stall
        m_allow_in = 1'b0;
        issue(32'h80000300, OP_B, 3'b001, 32'h10, 32'd1, 32'd2, 32'h80000304, 12'h321, 1'b1,
              1'b1, 32'h80000310, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_strobe_%0d", i), {31'b0, e_is_jump_instr}, (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("stall_allow_%0d", i), {31'b0, e_allow_in}, 32'd0);
        end
        check("stall_held_fact_pc", fact_pc, 32'h80000310);
        m_allow_in = 1'b1;
        @(negedge clk);
        check("stall_release_valid", {31'b0, e_valid}, 32'd0);

        // Wrong-path instruction offered during a mispredict is dropped
        issue(32'h80000400, OP_B, 3'b101, 32'd8, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000408, 12'h555, 1'b1,
              1'b0, 32'h80000404, 32'h0);
        d_pc = 32'h80000408; d_opcode = OP_ALU; d_is_jump_instr = 1'b0; d_to_e_valid = 1'b1;
        @(negedge clk);
        check("drop_flush", {31'b0, e_flush}, 32'd1);
        @(negedge clk);
        d_to_e_valid = 1'b0;
        check("drop_valid", {31'b0, e_valid}, 32'd0);

        // Counters: one good and one bad branch after a fresh reset
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("cnt_rst_branch", branch_cnt, 32'd0);
        check("cnt_rst_mispred", mispred_cnt, 32'd0);
        issue(32'h80000010, OP_B, 3'b000, 32'h20, 32'd5, 32'd5, 32'h80000030, 12'hABC, 1'b1,
              1'b1, 32'h80000030, 32'h0);
        wait_empty();
        m_allow_in = 1'b0;
        issue(32'h80000300, OP_B, 3'b001, 32'h10, 32'd1, 32'd2, 32'h80000304, 12'h321, 1'b1,
              1'b1, 32'h80000310, 32'h0);
        @(negedge clk);
        @(negedge clk);
`ifdef BRU_PERF_CNT_EN
        check("cnt_branch", branch_cnt, 32'd2);
        check("cnt_mispred", mispred_cnt, 32'd1);
`else
        check("cnt_branch_off", branch_cnt, 32'd0);
        check("cnt_mispred_off", mispred_cnt, 32'd0);
`endif
        check("midstall_valid", {31'b0, e_valid}, 32'd1);

        // Asynchronous reset mid-stall takes effect without a clock edge
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, e_valid}, 32'd0);
        check("arst_strobe", {31'b0, e_is_jump_instr}, 32'd0);
        check("arst_allow", {31'b0, e_allow_in}, 32'd1);
        check("arst_branch_cnt", branch_cnt, 32'd0);
        check("arst_mispred_cnt", mispred_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_allow_in = 1'b1;
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_stage.md
Name: branch_resolve_stage

Overview:
Execute-side branch resolution stage; the consumer end of the fetch-stage predictor interface. Accepts decoded instructions over the valid/allow_in pipeline handshake, evaluates the real outcome of B-type, JAL and JALR instructions, and returns one training/redirect report per control-flow instruction. Also produces the link value and forwards the instruction to the memory stage.

Parameters:
N, 12, global history width; must match the fetch-stage predictor.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
d_to_e_valid  in  1  decode holds a valid instruction
e_allow_in  out  1  stage can accept this cycle
e_to_m_valid  out  1  instruction is ready for the memory stage
m_allow_in  in  1  memory stage can accept
d_pc  in  32  instruction PC
d_opcode  in  7  opcode
d_funct  in  10  {func7,func3}; only [2:0] is used here
d_imm  in  32  sign-extended immediate
d_rs1_val  in  32  rs1 operand (already forwarded)
d_rs2_val  in  32  rs2 operand
d_is_jump_instr  in  1  B, JAL or JALR
d_pred_taken  in  1  fetch prediction
d_pred_next_pc  in  32  PC that fetch actually steered to after this instruction
d_pred_history  in  N  GHR snapshot taken at prediction
e_valid  out  1  stage register holds a live instruction
e_is_jump_instr  out  1  resolution report strobe
fact_taken  out  1  actual direction
fact_success  out  1  prediction correct
train_history  out  N  registered d_pred_history
fact_pc  out  32  correct next PC
e_flush  out  1  squash younger instructions in fetch/decode
e_pc  out  32  registered PC
e_link  out  32  pc+4 for JAL/JALR, else 0
branch_cnt  out  32  resolved control-flow count (optional feature)
mispred_cnt  out  32  mispredict count (optional feature)

Behaviour:
- Handshake:
  - e_allow_in = ~e_valid | m_allow_in.
  - e_to_m_valid = e_valid.
  - Load: d_to_e_valid & e_allow_in & ~e_flush → capture all d_* inputs; e_valid <= 1.
  - Otherwise, if m_allow_in → e_valid <= 0.
  - A wrong-path instruction offered in the same cycle that e_flush is high is dropped.
- Reset (rst=0, asynchronous):
  - e_valid, reported, all payload registers, counters → 0.
  - Every output therefore resets to 0, except e_allow_in, which resets to 1.
- Direction (B-type, registered func3):
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - Any other func3 → not taken.
  - JAL and JALR are always taken.
- Target (all arithmetic 32-bit modulo, no carry out):
  - B and JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
- Results:
  - fact_pc = taken ? target : pc+4.
  - fact_success = (d_pred_next_pc == fact_pc); direction alone is insufficient.
- Report strobe:
  - e_is_jump_instr = e_valid & is_jump & ~reported.
  - reported is set on the cycle after the strobe, while the instruction stalls.
  - reported is cleared when a new instruction loads.
  - Result: exactly one training pulse per instruction, regardless of m_allow_in stalls.
- Redirect: e_flush = e_is_jump_instr & ~fact_success (single cycle, same cycle as the report).
- Outputs while not strobing: fact_taken, fact_success, fact_pc and train_history still reflect the held instruction; consumers qualify them with e_is_jump_instr.
- Non-jump instructions: e_is_jump_instr = 0 and e_link = 0; the instruction passes through normally.
- Simultaneous stage handoff: a new load and the departure of the old instruction in the same cycle is legal; the new report appears the following cycle.

Optional Feature:
BRU_PERF_CNT_EN.
- Defined:
  - branch_cnt increments on each e_is_jump_instr pulse.
  - mispred_cnt increments on each e_flush.
  - Both wrap at 2^32 and are cleared only by reset.
- Undefined: both ports are tied to 0; no counter flops are present.

Test Plan:
- BEQ at pc=0x80000010, imm=0x20, rs1=rs2=5, pred_next_pc=0x80000030 → one pulse with fact_taken=1, fact_success=1, fact_pc=0x80000030, e_flush=0.
- BLT with rs1=0xFFFFFFFF, rs2=1, pred_next_pc=pc+4 → fact_taken=1, fact_success=0, e_flush=1 for exactly 1 cycle, fact_pc=pc+imm. The BLTU variant gives fact_taken=0, fact_success=1.
- JALR with rs1=0x80001003, imm=4, pc=0x80000100 → fact_pc=0x80001006, e_link=0x80000104.
- BNE mispredict with m_allow_in held 0 for 5 cycles → e_is_jump_instr high only in the first cycle. e_allow_in=0 throughout the stall; the instruction proceeds once m_allow_in=1.
- Mispredict cycle with d_to_e_valid=1 → the offered instruction is not captured; e_valid=0 the next cycle, unless m_allow_in=0 holds the branch.
- Assert rst mid-stall → immediately e_valid=0 and e_is_jump_instr=0. With BRU_PERF_CNT_EN, counters read 2 and 1 after one good branch plus one bad branch, and 0 after reset.
